// File: rtl/float_div.sv
// IEEE-754 single-precision iterative divider (z = a / b), radix-2 restoring
// mantissa division with round-to-nearest-even and a fixed-latency done pulse.
module float_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic        done,
  output logic        busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] DIV    = 3'd2;
  localparam logic [2:0] NORM   = 3'd3;
  localparam logic [2:0] ROUND  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int unsigned MW = 24;
  localparam int unsigned QW = 27;
  localparam int unsigned RW = 26;
  localparam int unsigned EW = 10;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_BIT = CW'(QW - 1);

  logic [2:0]           state_q, state_d;
  logic [31:0]          a_q, b_q;
  logic [MW-1:0]        mb_q, mant_q;
  logic [RW-1:0]        rem_q;
  logic [QW-1:0]        q_q;
  logic [CW-1:0]        cnt_q;
  logic signed [EW-1:0] exp_q;
  logic                 sign_q, guard_q, sticky_q, skip_round_q;

  logic [7:0]           ea_c, eb_c;
  logic                 a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;
  logic                 special_c;
  logic [31:0]          special_z_c;
  logic                 rem_ge_c;
  logic [RW-1:0]        rem_next_c;
  logic [MW:0]          rnd_sum_c;
  logic signed [EW-1:0] rnd_exp_c;
  logic [31:0]          rnd_z_c;

  // Operand classification and special-case resolution
  always_comb begin
    ea_c     = a_q[30:23];
    eb_c     = b_q[30:23];
    a_zero_c = (ea_c == 8'h00);
    b_zero_c = (eb_c == 8'h00);
    a_inf_c  = (ea_c == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf_c  = (eb_c == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan_c  = (ea_c == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan_c  = (eb_c == 8'hFF) && (b_q[22:0] != 23'd0);
    special_c   = 1'b1;
    special_z_c = 32'd0;
    if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c))
      special_z_c = 32'h7FC00000;
    else if (a_inf_c || (b_zero_c && !a_zero_c))
      special_z_c = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
    else if (a_zero_c || b_inf_c)
      special_z_c = {a_q[31] ^ b_q[31], 31'd0};
    else
      special_c = 1'b0;
  end

  // One restoring step: subtract if it fits, then shift the remainder
  always_comb begin
    rem_ge_c   = (rem_q >= RW'(mb_q));
    rem_next_c = (rem_ge_c ? (rem_q - RW'(mb_q)) : rem_q) << 1;
  end

  // Round-to-nearest-even, carry renormalisation and range clamping
  always_comb begin
    rnd_sum_c = {1'b0, mant_q} + (MW+1)'(guard_q & (sticky_q | mant_q[0]));
    rnd_exp_c = rnd_sum_c[MW] ? (exp_q + 10'sd1) : exp_q;
    if (rnd_exp_c >= 10'sd255)
      rnd_z_c = {sign_q, 8'hFF, 23'd0};
    else if (rnd_exp_c <= 10'sd0)
      rnd_z_c = {sign_q, 31'd0};
    else
      rnd_z_c = {sign_q, rnd_exp_c[7:0], rnd_sum_c[MW] ? 23'd0 : rnd_sum_c[22:0]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = UNPACK;
      UNPACK:  state_d = special_c ? ROUND : DIV;
      DIV:     if (cnt_q == LAST_BIT) state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; mb_q <= '0; mant_q <= '0; rem_q <= '0; q_q <= '0;
      cnt_q <= '0; exp_q <= '0; sign_q <= 1'b0; guard_q <= 1'b0; sticky_q <= 1'b0;
      skip_round_q <= 1'b0; z <= '0; done <= 1'b0; busy <= 1'b0;
    end else begin
      done <= (state_d == DONE);
      busy <= (state_d != IDLE);
      case (state_q)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
        end
        UNPACK: begin
          sign_q       <= a_q[31] ^ b_q[31];
          skip_round_q <= special_c;
          if (special_c) z <= special_z_c;
          mb_q  <= {1'b1, b_q[22:0]};
          rem_q <= RW'({1'b1, a_q[22:0]});
          q_q   <= '0;
          cnt_q <= '0;
          exp_q <= $signed({2'b00, ea_c}) - $signed({2'b00, eb_c}) + 10'sd127;
        end
        DIV: begin
          q_q   <= {q_q[QW-2:0], rem_ge_c};
          rem_q <= rem_next_c;
          cnt_q <= cnt_q + CW'(1);
        end
        NORM: begin
          if (q_q[QW-1]) begin
            mant_q   <= q_q[26:3];
            guard_q  <= q_q[2];
            sticky_q <= q_q[1] | q_q[0] | (rem_q != '0);
          end else begin
            mant_q   <= q_q[25:2];
            guard_q  <= q_q[1];
            sticky_q <= q_q[0] | (rem_q != '0);
            exp_q    <= exp_q - 10'sd1;
          end
        end
        ROUND: if (!skip_round_q) z <= rnd_z_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div.sv
// Directed bench for float_div: integer-division reference model plus a
// per-cycle monitor of busy/done/z timing.
module tb_float_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] z;
  logic        done, busy;

  float_div dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                 .z(z), .done(done), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Outstanding operation expectation
  bit          active = 0;
  int          e_n, e_lat, e_zlat;
  logic [31:0] e_z;
  logic [31:0] prev_z = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_cnt, act, exp);
    end
  endtask

  // Reference: exact integer quotient of the significands, then RNE at 24 bits
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output bit sp);
    int ex, ey, e;
    bit s, xz, yz, xi, yi, xn, yn, g, st;
    longint unsigned num, den, qq, rm, mant;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0); yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0); yn = (ey == 255) && (y[22:0] != 0);
    sp = 1;
    r  = '0;
    if (xn || yn || (xz && yz) || (xi && yi)) r = 32'h7FC00000;
    else if (xi || (yz && !xz))               r = {s, 8'hFF, 23'd0};
    else if (xz || yi)                        r = {s, 31'd0};
    else begin
      sp  = 0;
      num = longint'({1'b1, x[22:0]}) << 26;
      den = longint'({1'b1, y[22:0]});
      qq  = num / den;
      rm  = num % den;
      e   = ex - ey + 127;
      if (qq >= (64'd1 << 26)) begin
        mant = qq >> 3; g = qq[2]; st = (qq[1:0] != 0) || (rm != 0);
      end else begin
        mant = qq >> 2; g = qq[1]; st = qq[0] || (rm != 0); e = e - 1;
      end
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
      if (e >= 255)    r = {s, 8'hFF, 23'd0};
      else if (e <= 0) r = {s, 31'd0};
      else             r = {s, 8'(e), 23'(mant)};
    end
  endfunction

  // Single compare process: every cycle checks busy, done and the held z
  always @(negedge clk) begin
    logic [31:0] xz;
    bit xb, xd;
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_z", z, 32'd0);
      active = 0;
      prev_z = '0;
    end else begin
      xb = active && (edge_cnt >= e_n) && (edge_cnt <= e_n + e_lat);
      xd = active && (edge_cnt == e_n + e_lat);
      xz = (active && edge_cnt >= e_n + e_zlat) ? e_z : prev_z;
      chk("busy", 32'(busy), 32'(xb));
      chk("done", 32'(done), 32'(xd));
      chk("z", z, xz);
      if (xd) begin
        prev_z = e_z;
        active = 0;
      end
    end
  end

  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] hand);
    logic [31:0] mz;
    bit sp;
    model(ta, tb_v, mz, sp);
    chk("model_vs_hand", mz, hand);
    @(posedge clk); #1;
    a = ta; b = tb_v; start = 1'b1;
    e_n = edge_cnt + 1; e_z = mz;
    e_lat = sp ? 2 : 30; e_zlat = sp ? 1 : 30;
    active = 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (active && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (active) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: no done within 60 edges, busy=%0b", busy);
      active = 0;
    end
    #1;
  endtask

  typedef struct { logic [31:0] x; logic [31:0] y; logic [31:0] r; } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000};
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB};
    vecs[2] = '{32'hC0F00000, 32'h40200000, 32'hC0400000};
    vecs[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000};
    vecs[4] = '{32'h00000000, 32'h00000000, 32'h7FC00000};
    vecs[5] = '{32'h80000000, 32'h7F800000, 32'h80000000};
    vecs[6] = '{32'h7F000000, 32'h00800000, 32'h7F800000};
    vecs[7] = '{32'h00800000, 32'h7F000000, 32'h00000000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].x, vecs[i].y, vecs[i].r);
      wait_done();
    end

    // Start pulsed mid-operation must be ignored
    launch(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (4) @(posedge clk);
    #1 a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();

    // Reset mid-division aborts with no done pulse
    launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_z", z, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    launch(32'hC0F00000, 32'h40200000, 32'hC0400000);
    wait_done();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
